// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared defaults and types for the register file
package reg_file_pkg;
  localparam int RF_W = 8;
  localparam int RF_D = 3;
  typedef logic [RF_D-1:0] reg_addr_t;
  typedef logic [RF_W-1:0] reg_word_t;
endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one combinational read port with bypass, zero-register and busy masking
module rf_read_port
  import reg_file_pkg::*;
#(
  parameter int W = RF_W,
  parameter int D = RF_D,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1
) (
  input  logic                    i_rst,
  input  logic                    i_we,
  input  logic [D-1:0]            i_waddr,
  input  logic [W-1:0]            i_wdata,
  input  logic [D-1:0]            i_raddr,
  input  logic [2**D-1:0][W-1:0]  i_regs,
  input  logic [2**D-1:0]         i_busy,
  output logic [W-1:0]            o_rdata,
  output logic                    o_busy
);
  logic w_zero;
  logic w_hit;
  // zero register takes precedence over bypass; reset blanks everything
  always_comb begin
    w_zero  = (ZERO_REG != 0) && (i_raddr == '0);
    w_hit   = (BYPASS != 0) && i_we && (i_waddr == i_raddr);
    o_rdata = (i_rst || w_zero) ? '0 : w_hit ? i_wdata : i_regs[i_raddr];
    o_busy  = (i_rst || w_zero || w_hit) ? 1'b0 : i_busy[i_raddr];
  end
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with two read ports, one write port and a busy scoreboard
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int W = RF_W,
  parameter int D = RF_D,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          RegWrite,
  input  logic [D-1:0]  WAddr,
  input  logic [W-1:0]  WData,
  input  logic [D-1:0]  RAddr1,
  input  logic [D-1:0]  RAddr2,
  output logic [W-1:0]  RData1,
  output logic [W-1:0]  RData2,
  input  logic          MarkBusy,
  input  logic [D-1:0]  BusyAddr,
  output logic          Busy1,
  output logic          Busy2,
  output logic          AnyBusy
);
  logic [2**D-1:0][W-1:0] r_regs;
  logic [2**D-1:0]        r_busy;
  logic                   r_any;
  logic                   w_we;
  logic                   w_mark;
  logic [2**D-1:0]        w_busy_nxt;
  // writes clear busy first so a same-cycle mark on that register wins
  always_comb begin
    w_we       = RegWrite && !((ZERO_REG != 0) && (WAddr == '0));
    w_mark     = MarkBusy && !((ZERO_REG != 0) && (BusyAddr == '0));
    w_busy_nxt = r_busy;
    if (w_we) w_busy_nxt[WAddr] = 1'b0;
    if (w_mark) w_busy_nxt[BusyAddr] = 1'b1;
  end
  // register, scoreboard and AnyBusy update; reset drops any pending write or mark
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_regs <= '0;
      r_busy <= '0;
      r_any  <= 1'b0;
    end else begin
      if (w_we) r_regs[WAddr] <= WData;
      r_busy <= w_busy_nxt;
      r_any  <= |w_busy_nxt;
    end
  end
  assign AnyBusy = Reset ? 1'b0 : r_any;
  rf_read_port #(.W(W), .D(D), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)) u_rp1 (
    .i_rst(Reset), .i_we(RegWrite), .i_waddr(WAddr), .i_wdata(WData), .i_raddr(RAddr1),
    .i_regs(r_regs), .i_busy(r_busy), .o_rdata(RData1), .o_busy(Busy1)
  );
  rf_read_port #(.W(W), .D(D), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)) u_rp2 (
    .i_rst(Reset), .i_we(RegWrite), .i_waddr(WAddr), .i_wdata(WData), .i_raddr(RAddr2),
    .i_regs(r_regs), .i_busy(r_busy), .o_rdata(RData2), .o_busy(Busy2)
  );
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed checks of a bypassing zero-reg file and a plain one fed the same stimulus
module tb_reg_file_sb;
  import reg_file_pkg::*;
  logic CLK = 0, Reset = 1, RegWrite = 0, MarkBusy = 0;
  reg_addr_t WAddr = 0, RAddr1 = 0, RAddr2 = 0, BusyAddr = 0;
  reg_word_t WData = 0;
  reg_word_t rd1_a, rd2_a, rd1_b, rd2_b;
  logic busy1_a, busy2_a, any_a, busy1_b, busy2_b, any_b;
  int errors = 0, checks = 0;

  always #5 CLK = ~CLK;

  reg_file_sb #(.W(8), .D(3), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .CLK(CLK), .Reset(Reset), .RegWrite(RegWrite), .WAddr(WAddr), .WData(WData),
    .RAddr1(RAddr1), .RAddr2(RAddr2), .RData1(rd1_a), .RData2(rd2_a),
    .MarkBusy(MarkBusy), .BusyAddr(BusyAddr), .Busy1(busy1_a), .Busy2(busy2_a), .AnyBusy(any_a)
  );
  reg_file_sb #(.W(8), .D(3), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .CLK(CLK), .Reset(Reset), .RegWrite(RegWrite), .WAddr(WAddr), .WData(WData),
    .RAddr1(RAddr1), .RAddr2(RAddr2), .RData1(rd1_b), .RData2(rd2_b),
    .MarkBusy(MarkBusy), .BusyAddr(BusyAddr), .Busy1(busy1_b), .Busy2(busy2_b), .AnyBusy(any_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RegWrite = 1; WAddr = 3; WData = 8'h11; RAddr1 = 3;
    #1;
    chk("rst_forced_rd", rd1_a, 0);
    chk("rst_forced_any", any_a, 0);
    tick();
    Reset = 0; RegWrite = 0;
    #1;
    chk("rst_lost_write", rd1_a, 0);

    RegWrite = 1; WAddr = 3; WData = 8'hA5;
    tick();
    RegWrite = 0; RAddr1 = 3;
    #1;
    chk("wr_r3", rd1_a, 8'hA5);
    Reset = 1;
    #1;
    chk("rst_high_rd", rd1_a, 0);
    tick();
    Reset = 0;
    #1;
    chk("rst_clr_rd", rd1_a, 0);
    chk("rst_clr_busy", busy1_a, 0);
    chk("rst_clr_any", any_a, 0);

    RegWrite = 1; WAddr = 5; WData = 8'h3C; RAddr1 = 5;
    #1;
    chk("byp_same_cycle", rd1_a, 8'h3C);
    chk("nobyp_old", rd1_b, 8'h00);
    tick();
    RegWrite = 0;
    #1;
    chk("byp_after", rd1_a, 8'h3C);
    chk("nobyp_after", rd1_b, 8'h3C);

    MarkBusy = 1; BusyAddr = 2; RAddr1 = 2;
    #1;
    chk("mark_no_early", busy1_a, 0);
    tick();
    MarkBusy = 0;
    #1;
    chk("mark_busy1", busy1_a, 1);
    chk("mark_any", any_a, 1);
    chk("mark_busy1_b", busy1_b, 1);
    RegWrite = 1; WAddr = 2; WData = 8'h11;
    #1;
    chk("wb_byp_busy", busy1_a, 0);
    chk("wb_byp_data", rd1_a, 8'h11);
    chk("wb_nobyp_busy", busy1_b, 1);
    tick();
    RegWrite = 0;
    #1;
    chk("wb_busy_clr", busy1_a, 0);
    chk("wb_any_clr", any_a, 0);
    chk("wb_data", rd1_a, 8'h11);

    RegWrite = 1; MarkBusy = 1; WAddr = 4; BusyAddr = 4; WData = 8'h77; RAddr2 = 4;
    tick();
    RegWrite = 0; MarkBusy = 0;
    #1;
    chk("wm_data", rd2_a, 8'h77);
    chk("wm_busy", busy2_a, 1);
    chk("wm_any", any_a, 1);

    RegWrite = 1; WAddr = 4; WData = 8'h78; MarkBusy = 1; BusyAddr = 6;
    tick();
    RegWrite = 0; MarkBusy = 0; RAddr1 = 4; RAddr2 = 6;
    #1;
    chk("ind_data", rd1_a, 8'h78);
    chk("ind_busy_clr", busy1_a, 0);
    chk("ind_busy_set", busy2_a, 1);
    chk("ind_any", any_a, 1);
    RegWrite = 1; WAddr = 6; WData = 8'h66;
    tick();
    RegWrite = 0;
    #1;
    chk("ind_any_clr", any_a, 0);

    RegWrite = 1; WAddr = 0; WData = 8'hFF; MarkBusy = 1; BusyAddr = 0; RAddr1 = 0; RAddr2 = 0;
    #1;
    chk("z_rd1_same", rd1_a, 0);
    chk("z_rd2_same", rd2_a, 0);
    chk("z_busy1_same", busy1_a, 0);
    chk("z_busy2_same", busy2_a, 0);
    tick();
    RegWrite = 0; MarkBusy = 0;
    #1;
    chk("z_rd1", rd1_a, 0);
    chk("z_rd2", rd2_a, 0);
    chk("z_busy1", busy1_a, 0);
    chk("z_busy2", busy2_a, 0);
    chk("z_any", any_a, 0);
    chk("noz_rd1", rd1_b, 8'hFF);
    chk("noz_busy1", busy1_b, 1);

    RegWrite = 1; WAddr = 7; WData = 8'h5A;
    tick();
    RegWrite = 0; RAddr1 = 7; RAddr2 = 7;
    #1;
    chk("dual_rd1", rd1_a, 8'h5A);
    chk("dual_rd2", rd2_a, 8'h5A);
    Reset = 1; RegWrite = 1; WAddr = 7; WData = 8'h55; MarkBusy = 1; BusyAddr = 7;
    tick();
    Reset = 0; RegWrite = 0; MarkBusy = 0;
    #1;
    chk("rstprio_rd1", rd1_a, 0);
    chk("rstprio_rd2", rd2_a, 0);
    chk("rstprio_busy", busy1_a, 0);
    chk("rstprio_any", any_a, 0);
    chk("rstprio_rd_b", rd1_b, 0);
    chk("rstprio_any_b", any_b, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
